svo_enc_stream: RTL and testbench
=================================

// Module: svo_enc_stream
// PURPOSE
//  Parametrised video timing encoder. Merges an AXI-stream pixel input with
//  internally generated raster timing into one output stream: pixel data plus
//  sof/hsync/vsync/blank flags. Sits between the frame source and the TMDS/HDMI
//  serialiser.
//  Adds to the existing encoder:
//  - generic FIFO depth
//  - sync polarity control
//  - underrun fill mode
//  - status counters
// PARAMETERS
//  BPP        24  pixel data width (bits)
//  XY_BITS    12  width of the h/v cursors; must hold H_TOTAL-1 and V_TOTAL-1
//  H_FP,H_SYNC,H_BP,H_ACT  88,44,148,1920  horizontal timing, in pixels
//  V_FP,V_SYNC,V_BP,V_ACT  4,5,36,1080     vertical timing, in lines
//  HS_POL,VS_POL  1,1  1 = sync flag high during sync; 0 = inverted
//  PIX_AW     3   pixel FIFO depth = 2**PIX_AW (PIX_AW >= 2)
//  PRIME_LVL  6   pixel FIFO fill required before output starts (< 2**PIX_AW)
//  FILL_EN    0   1 = on underrun, emit FILL_RGB; 0 = stall
//  FILL_RGB   0   data emitted on an underrun
// PORTS
//  clk             in  1    clock
//  resetn          in  1    asynchronous active-low reset
//  in_axis_tvalid  in  1    input pixel valid
//  in_axis_tready  out 1    input ready, registered
//  in_axis_tdata   in  BPP  input pixel
//  in_axis_tuser   in  1    input start of frame
//  out_axis_tvalid out 1    output valid
//  out_axis_tready in  1    output ready
//  out_axis_tdata  out BPP  output pixel; 0 while blanking
//  out_axis_tuser  out 4    {blank, vsync, hsync, sof}
//  underflow       out 1    sticky: an active pixel had no data after priming
//  drop_count      out 16   pixels dropped during SOF resync; saturates at FFFF
//  clear_status    in  1    1-cycle pulse; clears underflow and drop_count
// BEHAVIOUR
//  - Reset (async assert, sync release): all outputs 0, cursors 0, FIFOs empty,
//    primed=0.
//  - Raster order per line: FP, SYNC, BP, then ACT.
//    H_TOTAL = sum of the four H values; V_TOTAL likewise.
//    blank = h or v outside its ACT region.
//    sof   = (h==0 && v==0).
//    hsync/vsync = HS_POL/VS_POL during sync, inverted otherwise.
//    Vertical sync is line-based and does not depend on h.
//  - Cursor wrap: h==H_TOTAL-1 -> h=0 and v advances; v==V_TOTAL-1 -> v=0.
//    The cursor advances only when a word is written to the output FIFO.
//  - Pixel FIFO: 2**PIX_AW entries, each {tuser, tdata}.
//    Write on tvalid&&tready.
//    in_axis_tready <= (fill <= 2**PIX_AW-3), registered. This leaves 2 slots
//    of margin, so a beat accepted in the cycle tready falls is never lost.
//  - Merge step: at most 1 per cycle, only if the 4-entry output FIFO is not
//    full. Priority order:
//    a) sof position, pixel head present with tuser=0: pop the pixel;
//       drop_count++ (saturating). Cursor holds.
//    b) blank: emit {ctrl, 0}; cursor advances; no pixel pop.
//    c) active, pixel present: emit {ctrl, pixel}; pop; cursor advances.
//    d) active, FIFO empty, primed, FILL_EN=1: emit {ctrl, FILL_RGB};
//       underflow<=1. With FILL_EN=0, or before priming, stall.
//  - Priming: primed is set once pixel fill >= PRIME_LVL and the output FIFO
//    is full. The output side stays idle (tvalid=0) until primed.
//    primed clears only on reset.
//  - Output: 1-entry skid register.
//    tvalid <= (output FIFO non-empty) after priming.
//    tdata/tuser are held stable while tvalid && !tready.
//    First tvalid is 1 cycle after primed sets.
//  - Status: clear_status wins over a same-cycle set or increment.
//  - Mid-operation reset: all state is lost. After release, priming and
//    SOF resync restart.
// TESTING
//  Small raster for all tests: H 1/1/1/4, V 1/1/1/2 (35 words/frame),
//  PIX_AW=3, PRIME_LVL=6.
//  1) Continuous frames, SOF on the first pixel, tready=1 ->
//     - 35 words per frame
//     - sof exactly on word 0
//     - hsync on h=1; vsync on v=1 lines
//     - 8 active words, in order
//  2) 3 junk pixels (tuser=0) before the SOF pixel -> drop_count=3;
//     the first active word carries the SOF pixel's data.
//  3) Random out_axis_tready at 30% ->
//     - no lost or duplicated words
//     - data stable while stalled
//     - in_axis_tready never accepts into a full FIFO
//  4) FILL_EN=1 with a FILL_RGB value, input stops mid-frame ->
//     remaining active words = FILL_RGB, underflow=1, timing cadence kept.
//     clear_status -> underflow=0.
//  5) FILL_EN=0, same starvation -> tvalid stalls;
//     resume input -> stream continues with no gap in the timing sequence.
//  6) resetn asserted asynchronously mid-line -> outputs 0 immediately.
//     After release, no output until primed again.

Source files
------------

// File: rtl/svo_enc_stream.sv
// svo_enc_stream: video timing encoder.
// Merges an AXI-stream pixel input with an internally generated raster. The
// output stream carries the pixel data and the {blank, vsync, hsync, sof} flags.
// Structure: pixel FIFO -> merge step -> 4-entry output FIFO -> output skid register.
module svo_enc_stream #(
  parameter int             BPP       = 24,
  parameter int             XY_BITS   = 12,
  parameter int             H_FP      = 88,
  parameter int             H_SYNC    = 44,
  parameter int             H_BP      = 148,
  parameter int             H_ACT     = 1920,
  parameter int             V_FP      = 4,
  parameter int             V_SYNC    = 5,
  parameter int             V_BP      = 36,
  parameter int             V_ACT     = 1080,
  parameter logic           HS_POL    = 1'b1,
  parameter logic           VS_POL    = 1'b1,
  parameter int             PIX_AW    = 3,
  parameter int             PRIME_LVL = 6,
  parameter logic           FILL_EN   = 1'b0,
  parameter logic [BPP-1:0] FILL_RGB  = '0
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           in_axis_tvalid,
  output logic           in_axis_tready,
  input  logic [BPP-1:0] in_axis_tdata,
  input  logic           in_axis_tuser,
  output logic           out_axis_tvalid,
  input  logic           out_axis_tready,
  output logic [BPP-1:0] out_axis_tdata,
  output logic [3:0]     out_axis_tuser,
  output logic           underflow,
  output logic [15:0]    drop_count,
  input  logic           clear_status
);

  localparam int DEPTH   = 2**PIX_AW;
  localparam int H_TOTAL = H_FP + H_SYNC + H_BP + H_ACT;
  localparam int V_TOTAL = V_FP + V_SYNC + V_BP + V_ACT;

  localparam logic [XY_BITS-1:0] XY_ONE   = XY_BITS'(1);
  localparam logic [XY_BITS-1:0] H_SYNC0  = XY_BITS'(H_FP);
  localparam logic [XY_BITS-1:0] H_BP0    = XY_BITS'(H_FP + H_SYNC);
  localparam logic [XY_BITS-1:0] H_ACT0   = XY_BITS'(H_FP + H_SYNC + H_BP);
  localparam logic [XY_BITS-1:0] H_LAST   = XY_BITS'(H_TOTAL - 1);
  localparam logic [XY_BITS-1:0] V_SYNC0  = XY_BITS'(V_FP);
  localparam logic [XY_BITS-1:0] V_BP0    = XY_BITS'(V_FP + V_SYNC);
  localparam logic [XY_BITS-1:0] V_ACT0   = XY_BITS'(V_FP + V_SYNC + V_BP);
  localparam logic [XY_BITS-1:0] V_LAST   = XY_BITS'(V_TOTAL - 1);

  localparam logic [PIX_AW:0]    PIX_ONE  = (PIX_AW+1)'(1);
  localparam logic [PIX_AW:0]    TRDY_MAX = (PIX_AW+1)'(DEPTH - 3);
  localparam logic [PIX_AW:0]    PRIME_V  = (PIX_AW+1)'(PRIME_LVL);

  // pixel FIFO
  logic [BPP:0]      pix_mem [DEPTH];
  logic [PIX_AW:0]   pix_wp, pix_rp, pix_fill;
  logic              pix_wr, pix_rd, pix_empty;
  logic [BPP:0]      pix_head;

  // output FIFO
  logic [BPP+3:0]    of_mem [4];
  logic [2:0]        of_wp, of_rp, of_cnt;
  logic              of_wr, of_rd, of_full, of_empty;
  logic [BPP+3:0]    of_din_p0;

  // raster cursor and merge control
  logic [XY_BITS-1:0] h, v;
  logic               primed;
  logic               adv, drop, uf_set;
  logic               h_act, v_act, hs_in, vs_in, sof_pos, blank;
  logic [3:0]         ctrl;
  logic               sk_load;

  assign pix_wr    = in_axis_tvalid && in_axis_tready;
  assign pix_fill  = pix_wp - pix_rp;
  assign pix_empty = (pix_fill == '0);
  assign pix_head  = pix_mem[pix_rp[PIX_AW-1:0]];

  assign of_cnt    = of_wp - of_rp;
  assign of_full   = (of_cnt == 3'd4);
  assign of_empty  = (of_cnt == 3'd0);

  assign h_act   = (h >= H_ACT0);
  assign v_act   = (v >= V_ACT0);
  assign hs_in   = (h >= H_SYNC0) && (h < H_BP0);
  assign vs_in   = (v >= V_SYNC0) && (v < V_BP0);
  assign sof_pos = (h == '0) && (v == '0);
  assign blank   = !(h_act && v_act);
  assign ctrl    = {blank, vs_in ? VS_POL : ~VS_POL, hs_in ? HS_POL : ~HS_POL, sof_pos};

  // Skid register takes a word whenever it is empty or being consumed.
  assign sk_load = primed && !of_empty && (!out_axis_tvalid || out_axis_tready);
  assign of_rd   = sk_load;

  // Merge step: decide what, if anything, enters the output FIFO this cycle.
  // Before priming the SOF word is held back until a pixel is visible, so
  // leading non-SOF pixels get discarded instead of landing in active video.
  always_comb begin
    pix_rd    = 1'b0;
    of_wr     = 1'b0;
    of_din_p0 = '0;
    adv       = 1'b0;
    drop      = 1'b0;
    uf_set    = 1'b0;
    if (!of_full) begin
      if (sof_pos && !pix_empty && !pix_head[BPP]) begin
        pix_rd = 1'b1;
        drop   = 1'b1;
      end else if (sof_pos && !primed && pix_empty) begin
        adv = 1'b0;
      end else if (blank) begin
        of_wr     = 1'b1;
        of_din_p0 = {ctrl, {BPP{1'b0}}};
        adv       = 1'b1;
      end else if (!pix_empty) begin
        of_wr     = 1'b1;
        of_din_p0 = {ctrl, pix_head[BPP-1:0]};
        pix_rd    = 1'b1;
        adv       = 1'b1;
      end else if (primed) begin
        uf_set = 1'b1;
        if (FILL_EN) begin
          of_wr     = 1'b1;
          of_din_p0 = {ctrl, FILL_RGB};
          adv       = 1'b1;
        end
      end
    end
  end

  // FIFO storage arrays (data only, no reset needed).
  always_ff @(posedge clk) begin
    if (pix_wr) pix_mem[pix_wp[PIX_AW-1:0]] <= {in_axis_tuser, in_axis_tdata};
    if (of_wr)  of_mem[of_wp[1:0]]          <= of_din_p0;
  end

  // FIFO pointers, registered input ready and priming latch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pix_wp         <= '0;
      pix_rp         <= '0;
      of_wp          <= '0;
      of_rp          <= '0;
      in_axis_tready <= 1'b0;
      primed         <= 1'b0;
    end else begin
      if (pix_wr) pix_wp <= pix_wp + PIX_ONE;
      if (pix_rd) pix_rp <= pix_rp + PIX_ONE;
      if (of_wr)  of_wp  <= of_wp + 3'd1;
      if (of_rd)  of_rp  <= of_rp + 3'd1;
      in_axis_tready <= (pix_fill <= TRDY_MAX);
      if ((pix_fill >= PRIME_V) && of_full) primed <= 1'b1;
    end
  end

  // Raster cursor: moves only when a word enters the output FIFO.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h <= '0;
      v <= '0;
    end else if (adv) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + XY_ONE;
      end else begin
        h <= h + XY_ONE;
      end
    end
  end

  // Output skid register (stage p1): held while the sink stalls.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_axis_tvalid <= 1'b0;
      out_axis_tdata  <= '0;
      out_axis_tuser  <= '0;
    end else if (sk_load) begin
      out_axis_tvalid <= 1'b1;
      {out_axis_tuser, out_axis_tdata} <= of_mem[of_rp[1:0]];
    end else if (out_axis_tready) begin
      out_axis_tvalid <= 1'b0;
    end
  end

  // Status: clear_status takes priority over a same-cycle set/increment.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      underflow  <= 1'b0;
      drop_count <= '0;
    end else if (clear_status) begin
      underflow  <= 1'b0;
      drop_count <= '0;
    end else begin
      if (uf_set) underflow <= 1'b1;
      if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_svo_enc_stream.sv
// Directed bench for svo_enc_stream on a 7x5 raster (H 1/1/1/4, V 1/1/1/2).
// Two instances share the stimulus: d0 stalls on underrun, d1 fills.
module tb_svo_enc_stream;

  localparam logic [23:0] FILL = 24'hABCDEF;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_tvalid = 1'b0;
  logic [23:0] in_tdata = '0;
  logic        in_tuser = 1'b0;
  logic        out_tready = 1'b0;
  logic        clear_status = 1'b0;

  logic        d0_irdy, d0_ov, d0_uf, d1_irdy, d1_ov, d1_uf;
  logic [23:0] d0_od, d1_od;
  logic [3:0]  d0_ou, d1_ou;
  logic [15:0] d0_dc, d1_dc;

  logic        sel = 1'b0;
  logic        o_irdy, o_tvalid, o_uf;
  logic [23:0] o_tdata;
  logic [3:0]  o_tuser;
  logic [15:0] o_dc;

  assign o_irdy   = sel ? d1_irdy : d0_irdy;
  assign o_tvalid = sel ? d1_ov   : d0_ov;
  assign o_tdata  = sel ? d1_od   : d0_od;
  assign o_tuser  = sel ? d1_ou   : d0_ou;
  assign o_uf     = sel ? d1_uf   : d0_uf;
  assign o_dc     = sel ? d1_dc   : d0_dc;

  always #5 clk = ~clk;

  svo_enc_stream #(.BPP(24), .XY_BITS(12), .H_FP(1), .H_SYNC(1), .H_BP(1), .H_ACT(4),
    .V_FP(1), .V_SYNC(1), .V_BP(1), .V_ACT(2), .HS_POL(1'b1), .VS_POL(1'b1),
    .PIX_AW(3), .PRIME_LVL(6), .FILL_EN(1'b0), .FILL_RGB(FILL)) d0 (
    .clk(clk), .resetn(resetn), .in_axis_tvalid(in_tvalid), .in_axis_tready(d0_irdy),
    .in_axis_tdata(in_tdata), .in_axis_tuser(in_tuser), .out_axis_tvalid(d0_ov),
    .out_axis_tready(out_tready), .out_axis_tdata(d0_od), .out_axis_tuser(d0_ou),
    .underflow(d0_uf), .drop_count(d0_dc), .clear_status(clear_status));

  svo_enc_stream #(.BPP(24), .XY_BITS(12), .H_FP(1), .H_SYNC(1), .H_BP(1), .H_ACT(4),
    .V_FP(1), .V_SYNC(1), .V_BP(1), .V_ACT(2), .HS_POL(1'b1), .VS_POL(1'b1),
    .PIX_AW(3), .PRIME_LVL(6), .FILL_EN(1'b1), .FILL_RGB(FILL)) d1 (
    .clk(clk), .resetn(resetn), .in_axis_tvalid(in_tvalid), .in_axis_tready(d1_irdy),
    .in_axis_tdata(in_tdata), .in_axis_tuser(in_tuser), .out_axis_tvalid(d1_ov),
    .out_axis_tready(out_tready), .out_axis_tdata(d1_od), .out_axis_tuser(d1_ou),
    .underflow(d1_uf), .drop_count(d1_dc), .clear_status(clear_status));

  int          checks = 0;
  int          failures = 0;
  logic [24:0] src_q[$];
  int          src_i = 0;
  logic [27:0] got_q[$];
  logic        ready_mode = 1'b0;
  logic        ready_val = 1'b1;
  logic        prev_v = 1'b0;
  logic        prev_r = 1'b0;
  logic [27:0] prev_w = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected output word k of a frame: pixels numbered 0..7 in active area,
  // pixels at index >= nvalid are not present in the input and come out as FILL.
  function automatic logic [27:0] exp_word(input int k, input logic [23:0] base, input int nvalid);
    int h, v, idx;
    logic bl;
    logic [23:0] d;
    h  = k % 7;
    v  = k / 7;
    bl = (h < 3) || (v < 3);
    idx = (v - 3) * 4 + (h - 3);
    d  = bl ? 24'h0 : ((idx < nvalid) ? base + 24'(idx) : FILL);
    return {bl, (v == 1), (h == 1), (k == 0), d};
  endfunction

  task automatic push_part(input logic [23:0] base, input int first, input int n);
    for (int i = first; i < first + n; i++) src_q.push_back({(i == 0), base + 24'(i)});
  endtask

  // One clock: drive inputs at the falling edge and record the handshakes
  // that the following rising edge will perform.
  task automatic cyc();
    @(negedge clk);
    if (prev_v && !prev_r) begin
      chk("stall_valid", o_tvalid, 1);
      chk("stall_word", {o_tuser, o_tdata}, prev_w);
    end
    out_tready = ready_mode ? ($urandom_range(0, 9) < 3) : ready_val;
    if (src_i < src_q.size()) begin
      in_tvalid = 1'b1;
      {in_tuser, in_tdata} = src_q[src_i];
    end else begin
      in_tvalid = 1'b0;
    end
    if (in_tvalid && o_irdy) src_i++;
    if (o_tvalid && out_tready) got_q.push_back({o_tuser, o_tdata});
    prev_v = o_tvalid;
    prev_r = out_tready;
    prev_w = {o_tuser, o_tdata};
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    resetn = 1'b0;
    in_tvalid = 1'b0;
    clear_status = 1'b0;
    src_q.delete();
    got_q.delete();
    src_i = 0;
    prev_v = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    chk({tag, "_rst_tvalid"}, o_tvalid, 0);
    chk({tag, "_rst_word"}, {o_tuser, o_tdata}, 0);
    chk({tag, "_rst_irdy"}, o_irdy, 0);
    chk({tag, "_rst_status"}, {o_uf, o_dc}, 0);
  endtask

  task automatic collect(input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (got_q.size() < n && c < budget) begin
      cyc();
      c++;
    end
    chk({tag, "_count"}, got_q.size(), n);
  endtask

  // Frame f of the captured stream: bases per frame, frame 1 may be partial.
  task automatic check_words(input string tag, input int n, input logic [23:0] b0,
                             input logic [23:0] b1, input logic [23:0] b2, input int nv1);
    for (int k = 0; k < n && k < got_q.size(); k++) begin
      int f;
      logic [23:0] b;
      f = k / 35;
      b = (f == 0) ? b0 : ((f == 1) ? b1 : b2);
      chk($sformatf("%s_w%0d", tag, k), got_q[k], exp_word(k % 35, b, (f == 1) ? nv1 : 8));
    end
  endtask

  initial begin
    // Test 1: continuous frames, sink always ready.
    sel = 1'b0; ready_mode = 1'b0; ready_val = 1'b1;
    do_reset("t1");
    push_part(24'h100000, 0, 8);
    push_part(24'h100100, 0, 8);
    collect(70, 2000, "t1");
    check_words("t1", 70, 24'h100000, 24'h100100, 24'h0, 8);
    chk("t1_sof_w0", got_q.size() > 0 ? got_q[0][24] : 1'bx, 1);
    chk("t1_drop", o_dc, 0);

    // Test 2: three junk pixels ahead of SOF are dropped.
    do_reset("t2");
    for (int j = 0; j < 3; j++) src_q.push_back({1'b0, 24'hBAD000 + 24'(j)});
    push_part(24'h200000, 0, 8);
    push_part(24'h200100, 0, 8);
    collect(35, 2000, "t2");
    chk("t2_drop", o_dc, 3);
    chk("t2_first_act", got_q.size() > 24 ? got_q[24][23:0] : 24'hx, 24'h200000);
    check_words("t2", 35, 24'h200000, 24'h0, 24'h0, 8);

    // Test 3: random sink back-pressure.
    ready_mode = 1'b1;
    do_reset("t3");
    push_part(24'h300000, 0, 8);
    push_part(24'h300100, 0, 8);
    push_part(24'h300200, 0, 8);
    collect(105, 5000, "t3");
    check_words("t3", 105, 24'h300000, 24'h300100, 24'h300200, 8);
    ready_mode = 1'b0;

    // Test 4: fill mode, input stops three pixels into frame 2.
    sel = 1'b1; ready_val = 1'b1;
    do_reset("t4");
    push_part(24'h400000, 0, 8);
    push_part(24'h400100, 0, 3);
    collect(70, 2000, "t4");
    check_words("t4", 70, 24'h400000, 24'h400100, 24'h0, 3);
    chk("t4_underflow", o_uf, 1);
    ready_val = 1'b0;
    repeat (12) cyc();
    chk("t4_uf_held", o_uf, 1);
    clear_status = 1'b1;
    cyc();
    clear_status = 1'b0;
    chk("t4_uf_clear", o_uf, 0);

    // Test 5: stall mode starvation, then resume.
    sel = 1'b0; ready_val = 1'b1;
    do_reset("t5");
    push_part(24'h500000, 0, 8);
    push_part(24'h500100, 0, 3);
    collect(62, 2000, "t5a");
    repeat (40) cyc();
    chk("t5_stalled_count", got_q.size(), 62);
    chk("t5_stalled_tvalid", o_tvalid, 0);
    push_part(24'h500100, 3, 5);
    push_part(24'h500200, 0, 8);
    collect(105, 2000, "t5b");
    check_words("t5", 105, 24'h500000, 24'h500100, 24'h500200, 8);

    // Test 6: asynchronous reset mid-line.
    do_reset("t6");
    push_part(24'h600000, 0, 8);
    push_part(24'h600100, 0, 8);
    collect(10, 2000, "t6a");
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_async_tvalid", o_tvalid, 0);
    chk("t6_async_word", {o_tuser, o_tdata}, 0);
    chk("t6_async_irdy", o_irdy, 0);
    @(negedge clk);
    src_q.delete();
    got_q.delete();
    src_i = 0;
    prev_v = 1'b0;
    push_part(24'h610000, 0, 8);
    push_part(24'h610100, 0, 8);
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("t6_idle%0d", i), o_tvalid, 0);
    end
    collect(35, 2000, "t6b");
    check_words("t6", 35, 24'h610000, 24'h0, 24'h0, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
